axi_lite_mem_display: RTL and testbench

Parametrised AXI4-Lite slave: a DEPTH-word register memory with independent write (AW/W/B) and read (AR/R) channels, byte strobes, error responses and a multiplexed 4-digit seven-segment readout of the last read word. Sits between the bus master and the board display; it is the next generation of the team's single-digit AXI memory/display block.

---
 rtl/axi_lite_mem_display_pkg.sv | 35 +++
 rtl/axi_lite_mem_display_if.sv | 37 +++
 rtl/axi_lite_mem_display_seg_scan.sv | 41 ++++
 rtl/axi_lite_mem_display.sv | 179 +++++++++++++++++
 tb/tb_axi_lite_mem_display.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/axi_lite_mem_display_pkg.sv
// Shared constants, FSM state types and the seven-segment pattern table
// for the AXI4-Lite memory/display block.
package axi_mem_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_e;
    typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_e;

    // Active-low segments, bit 7 = a ... bit 1 = g, bit 0 = dp (always off).
    function automatic logic [7:0] seg_pattern(input logic [3:0] nib);
        logic [7:0] pat;
        case (nib)
            4'h0: pat = 8'h03;
            4'h1: pat = 8'h9F;
            4'h2: pat = 8'h25;
            4'h3: pat = 8'h0D;
            4'h4: pat = 8'h99;
            4'h5: pat = 8'h49;
            4'h6: pat = 8'h41;
            4'h7: pat = 8'h1F;
            4'h8: pat = 8'h01;
            4'h9: pat = 8'h09;
            4'hA: pat = 8'h11;
            4'hB: pat = 8'hC1;
            4'hC: pat = 8'h63;
            4'hD: pat = 8'h85;
            4'hE: pat = 8'h61;
            default: pat = 8'h71;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/axi_lite_mem_display_if.sv
// AXI4-Lite write/read channel bundle between bus master (ms_*) and slave (sm_*).
interface axi_lite_mem_display_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
);
    logic                  ms_awvalid;
    logic                  sm_awready;
    logic [ADDR_W-1:0]     ms_awaddr;
    logic                  ms_wvalid;
    logic                  sm_wready;
    logic [DATA_W-1:0]     ms_wdata;
    logic [DATA_W/8-1:0]   ms_wstrb;
    logic                  sm_bvalid;
    logic                  ms_bready;
    logic [1:0]            sm_bresp;
    logic                  ms_arvalid;
    logic                  sm_arready;
    logic [ADDR_W-1:0]     ms_araddr;
    logic                  sm_rvalid;
    logic                  ms_rready;
    logic [DATA_W-1:0]     sm_rdata;
    logic [1:0]            sm_rresp;

    modport slave (
        input  ms_awvalid, ms_awaddr, ms_wvalid, ms_wdata, ms_wstrb, ms_bready,
               ms_arvalid, ms_araddr, ms_rready,
        output sm_awready, sm_wready, sm_bvalid, sm_bresp,
               sm_arready, sm_rvalid, sm_rdata, sm_rresp
    );

    modport master (
        output ms_awvalid, ms_awaddr, ms_wvalid, ms_wdata, ms_wstrb, ms_bready,
               ms_arvalid, ms_araddr, ms_rready,
        input  sm_awready, sm_wready, sm_bvalid, sm_bresp,
               sm_arready, sm_rvalid, sm_rdata, sm_rresp
    );
endinterface

// File: rtl/axi_lite_mem_display_seg_scan.sv
// Multiplexed 4-digit seven-segment driver: free-running scan counter selects
// digit k every 2^SCAN_W cycles and shows nibble k of word_i.
module seg_scan
    import axi_mem_pkg::*;
#(
    parameter int SCAN_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] word_i,
    output logic [7:0]  seg_o,
    output logic [3:0]  an_o
);
    logic [SCAN_W+1:0] cnt_q;
    logic [1:0]        digit;
    logic [3:0]        nib;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + (SCAN_W + 2)'(1);
        end
    end

    assign digit = cnt_q[SCAN_W+1:SCAN_W];
    assign an_o  = ~(4'b0001 << digit);

    always_comb begin
        nib = word_i[3:0];
        case (digit)
            2'd1:    nib = word_i[7:4];
            2'd2:    nib = word_i[11:8];
            2'd3:    nib = word_i[15:12];
            default: nib = word_i[3:0];
        endcase
    end

    assign seg_o = seg_pattern(nib);

endmodule

// File: rtl/axi_lite_mem_display.sv
// AXI4-Lite DEPTH-word register memory with byte strobes and SLVERR on out-of-range
// addresses; last read word drives the display (AXI_MEM_HEXDISP_EN selects hex scan).
module axi_lite_mem_display
    import axi_mem_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 12,
    parameter int SCAN_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    axi_lite_mem_display_if.slave bus,
    output logic [7:0]            disp_hex_r,
    output logic [3:0]            an
);
    localparam int              STRB_W  = DATA_W / 8;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
`ifdef AXI_MEM_HEXDISP_EN
    localparam int DISP_W = 16;
`else
    localparam int DISP_W = 8;
`endif

    if (DATA_W % 8 != 0 || DATA_W < 16 || DEPTH < 1 || DEPTH > (1 << ADDR_W) || SCAN_W < 1)
    begin : g_bad_param
        $error("axi_lite_mem_display: illegal parameter set");
    end

    logic [DATA_W-1:0] mem_q [DEPTH];

    w_state_e          w_state_q, w_state_d;
    r_state_e          r_state_q, r_state_d;
    logic              awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
    logic [1:0]        bresp_q, rresp_q;
    logic              aw_held_q, w_held_q;
    logic [ADDR_W-1:0] awaddr_q;
    logic [DATA_W-1:0] wdata_q, rdata_q;
    logic [STRB_W-1:0] wstrb_q;
    logic [DISP_W-1:0] disp_word_q;

    logic              aw_hs, w_hs, b_hs, ar_hs, r_hs, commit, w_ok, r_ok;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;

    assign aw_hs = bus.ms_awvalid & awready_q;
    assign w_hs  = bus.ms_wvalid & wready_q;
    assign b_hs  = bvalid_q & bus.ms_bready;
    assign ar_hs = (r_state_q == R_IDLE) & bus.ms_arvalid & arready_q;
    assign r_hs  = rvalid_q & bus.ms_rready;

    // A channel handshaking this cycle merges with one latched earlier.
    assign waddr  = aw_held_q ? awaddr_q : bus.ms_awaddr;
    assign wdata  = w_held_q  ? wdata_q  : bus.ms_wdata;
    assign wstrb  = w_held_q  ? wstrb_q  : bus.ms_wstrb;
    assign commit = (w_state_q == W_IDLE) & (aw_held_q | aw_hs) & (w_held_q | w_hs);
    assign w_ok   = {1'b0, waddr} < DEPTH_L;
    assign r_ok   = {1'b0, bus.ms_araddr} < DEPTH_L;

    always_comb begin
        w_state_d = w_state_q;
        case (w_state_q)
            W_IDLE:  if (commit) w_state_d = W_RESP;
            default: if (b_hs)   w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        case (r_state_q)
            R_IDLE:  if (ar_hs) r_state_d = R_DATA;
            default: if (r_hs)  r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            if (commit) begin
                awready_q <= 1'b0;
                wready_q  <= 1'b0;
                aw_held_q <= 1'b0;
                w_held_q  <= 1'b0;
                bvalid_q  <= 1'b1;
                bresp_q   <= w_ok ? RESP_OKAY : RESP_SLVERR;
            end else begin
                if (aw_hs) begin
                    aw_held_q <= 1'b1;
                    awaddr_q  <= bus.ms_awaddr;
                    awready_q <= 1'b0;
                end
                if (w_hs) begin
                    w_held_q <= 1'b1;
                    wdata_q  <= bus.ms_wdata;
                    wstrb_q  <= bus.ms_wstrb;
                    wready_q <= 1'b0;
                end
                if (b_hs) begin
                    bvalid_q  <= 1'b0;
                    awready_q <= 1'b1;
                    wready_q  <= 1'b1;
                end
            end
        end
    end

    // Reads sample mem_q before this edge's write lands, so a colliding read sees old data.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= DATA_W'(i);
            end
        end else if (commit && w_ok) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) begin
                    mem_q[waddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q   <= R_IDLE;
            arready_q   <= 1'b1;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            rresp_q     <= RESP_OKAY;
            disp_word_q <= '0;
        end else begin
            r_state_q <= r_state_d;
            if (ar_hs) begin
                arready_q <= 1'b0;
                rvalid_q  <= 1'b1;
                rdata_q   <= r_ok ? mem_q[bus.ms_araddr] : '0;
                rresp_q   <= r_ok ? RESP_OKAY : RESP_SLVERR;
            end else if (r_hs) begin
                arready_q   <= 1'b1;
                rvalid_q    <= 1'b0;
                disp_word_q <= rdata_q[DISP_W-1:0];
            end
        end
    end

    assign bus.sm_awready = awready_q;
    assign bus.sm_wready  = wready_q;
    assign bus.sm_bvalid  = bvalid_q;
    assign bus.sm_bresp   = bresp_q;
    assign bus.sm_arready = arready_q;
    assign bus.sm_rvalid  = rvalid_q;
    assign bus.sm_rdata   = rdata_q;
    assign bus.sm_rresp   = rresp_q;

`ifdef AXI_MEM_HEXDISP_EN
    seg_scan #(.SCAN_W(SCAN_W)) u_seg_scan (
        .clk    (clk),
        .reset  (reset),
        .word_i (disp_word_q),
        .seg_o  (disp_hex_r),
        .an_o   (an)
    );
`else
    assign an         = 4'b1110;
    assign disp_hex_r = disp_word_q;
`endif

endmodule

// File: tb/tb_axi_lite_mem_display.sv
// Scoreboard bench: stimulus queues expected B/R responses, a negedge monitor pops them.
module tb_axi_lite_mem_display;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] disp_hex_r;
    logic [3:0] an;
    int         checks   = 0;
    int         failures = 0;

    logic [17:0] rd_exp_q [$];
    logic [1:0]  wr_exp_q [$];
    logic [17:0] rexp;
    logic [1:0]  wexp;

`ifdef AXI_MEM_HEXDISP_EN
    localparam logic [7:0] DISP_RST = 8'h03;
    localparam logic [7:0] DISP_5   = 8'h49;
    localparam logic [7:0] DISP_9   = 8'h09;
`else
    localparam logic [7:0] DISP_RST = 8'h00;
    localparam logic [7:0] DISP_5   = 8'h05;
    localparam logic [7:0] DISP_9   = 8'h09;
`endif

    axi_lite_mem_display_if #(.ADDR_W(4), .DATA_W(16)) bus ();

    axi_lite_mem_display #(
        .ADDR_W(4), .DATA_W(16), .DEPTH(12), .SCAN_W(16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .disp_hex_r (disp_hex_r),
        .an         (an)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    always @(negedge clk) begin
        if (!reset && bus.sm_rvalid && bus.ms_rready) begin
            if (rd_exp_q.size() == 0) fail_now("unexpected_r_beat");
            else begin
                rexp = rd_exp_q.pop_front();
                check("rdata", 32'(bus.sm_rdata), 32'(rexp[17:2]));
                check("rresp", 32'(bus.sm_rresp), 32'(rexp[1:0]));
            end
        end
        if (!reset && bus.sm_bvalid && bus.ms_bready) begin
            if (wr_exp_q.size() == 0) fail_now("unexpected_b_beat");
            else begin
                wexp = wr_exp_q.pop_front();
                check("bresp", 32'(bus.sm_bresp), 32'(wexp));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [3:0] a, input logic [15:0] ed, input logic [1:0] er);
        int n;
        bit done, hs;
        rd_exp_q.push_back({ed, er});
        bus.ms_araddr  = a;
        bus.ms_arvalid = 1'b1;
        n = 0; done = 1'b0;
        while (!done && n < 20) begin
            hs = bus.sm_arready;
            tick(); n++;
            if (hs) done = 1'b1;
        end
        bus.ms_arvalid = 1'b0;
        if (!done) fail_now("ar_timeout");
        check("rvalid_latency", 32'(bus.sm_rvalid), 32'd1);
        n = 0;
        while (bus.sm_rvalid && n < 20) begin tick(); n++; end
        if (bus.sm_rvalid) fail_now("r_timeout");
    endtask

    task automatic do_write(input logic [3:0] a, input logic [15:0] d, input logic [1:0] s,
                            input int lead, input logic [1:0] er, input bit expect_b);
        int n;
        bit aw_done, w_done, aw_hs, w_hs;
        if (expect_b) wr_exp_q.push_back(er);
        bus.ms_awaddr  = a;
        bus.ms_wdata   = d;
        bus.ms_wstrb   = s;
        bus.ms_awvalid = 1'b1;
        bus.ms_wvalid  = (lead == 0);
        aw_done = 1'b0; w_done = 1'b0; n = 0;
        while (!(aw_done && w_done) && n < 20) begin
            aw_hs = bus.ms_awvalid && bus.sm_awready;
            w_hs  = bus.ms_wvalid && bus.sm_wready;
            tick(); n++;
            if (aw_hs) begin bus.ms_awvalid = 1'b0; aw_done = 1'b1; end
            if (w_hs)  begin bus.ms_wvalid  = 1'b0; w_done  = 1'b1; end
            if (!w_done && n >= lead) bus.ms_wvalid = 1'b1;
        end
        if (!(aw_done && w_done)) fail_now("aw_w_timeout");
        check("bvalid_latency", 32'(bus.sm_bvalid), 32'd1);
        if (expect_b) begin
            n = 0;
            while (bus.sm_bvalid && n < 20) begin tick(); n++; end
            if (bus.sm_bvalid) fail_now("b_timeout");
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.ms_awvalid = 1'b0; bus.ms_awaddr = '0;
        bus.ms_wvalid  = 1'b0; bus.ms_wdata  = '0; bus.ms_wstrb = '0;
        bus.ms_bready  = 1'b1;
        bus.ms_arvalid = 1'b0; bus.ms_araddr = '0;
        bus.ms_rready  = 1'b1;
        tick(); tick();
        reset = 1'b0;

        check("rst_awready", 32'(bus.sm_awready), 32'd1);
        check("rst_wready",  32'(bus.sm_wready),  32'd1);
        check("rst_arready", 32'(bus.sm_arready), 32'd1);
        check("rst_bvalid",  32'(bus.sm_bvalid),  32'd0);
        check("rst_rvalid",  32'(bus.sm_rvalid),  32'd0);
        check("rst_bresp",   32'(bus.sm_bresp),   32'd0);
        check("rst_rresp",   32'(bus.sm_rresp),   32'd0);
        check("rst_rdata",   32'(bus.sm_rdata),   32'd0);
        check("rst_an",      32'(an),             32'hE);
        check("rst_disp",    32'(disp_hex_r),     32'(DISP_RST));

        do_read(4'd5, 16'h0005, 2'b00);
        check("disp_after_rd5", 32'(disp_hex_r), 32'(DISP_5));
        check("an_after_rd5",   32'(an),          32'hE);

        do_write(4'd3, 16'hBEEF, 2'b01, 1, 2'b00, 1'b1);
        do_read(4'd3, 16'h00EF, 2'b00);

        do_write(4'd14, 16'hFFFF, 2'b11, 0, 2'b10, 1'b1);
        do_read(4'd14, 16'h0000, 2'b10);
        do_read(4'd6,  16'h0006, 2'b00);
        do_read(4'd10, 16'h000A, 2'b00);

        do_write(4'd4, 16'hABCD, 2'b10, 2, 2'b00, 1'b1);
        do_read(4'd4, 16'hAB04, 2'b00);

        // Held R beat under backpressure; a second AR must not be taken.
        bus.ms_rready = 1'b0;
        rd_exp_q.push_back({16'h0009, 2'b00});
        bus.ms_araddr = 4'd9; bus.ms_arvalid = 1'b1;
        tick();
        bus.ms_araddr = 4'd2;
        for (int i = 0; i < 5; i++) begin
            check("stall_rvalid",  32'(bus.sm_rvalid),  32'd1);
            check("stall_rdata",   32'(bus.sm_rdata),   32'h0009);
            check("stall_arready", 32'(bus.sm_arready), 32'd0);
            tick();
        end
        bus.ms_arvalid = 1'b0;
        bus.ms_rready  = 1'b1;
        tick();
        check("stall_release_rvalid", 32'(bus.sm_rvalid), 32'd0);
        tick(); tick();
        check("no_second_read", 32'(bus.sm_rvalid), 32'd0);
        check("disp_after_rd9", 32'(disp_hex_r),    32'(DISP_9));

        // Same-cycle AR and write commit at address 7.
        rd_exp_q.push_back({16'h0007, 2'b00});
        wr_exp_q.push_back(2'b00);
        bus.ms_awaddr = 4'd7; bus.ms_wdata = 16'h1234; bus.ms_wstrb = 2'b11;
        bus.ms_araddr = 4'd7;
        check("coll_ready_all", 32'({bus.sm_awready, bus.sm_wready, bus.sm_arready}), 32'h7);
        bus.ms_awvalid = 1'b1; bus.ms_wvalid = 1'b1; bus.ms_arvalid = 1'b1;
        tick();
        bus.ms_awvalid = 1'b0; bus.ms_wvalid = 1'b0; bus.ms_arvalid = 1'b0;
        check("coll_bvalid", 32'(bus.sm_bvalid), 32'd1);
        check("coll_rvalid", 32'(bus.sm_rvalid), 32'd1);
        tick();
        check("coll_done", 32'({bus.sm_bvalid, bus.sm_rvalid}), 32'd0);
        do_read(4'd7, 16'h1234, 2'b00);

        // Reset while a write response is pending.
        bus.ms_bready = 1'b0;
        do_write(4'd3, 16'hBEEF, 2'b11, 0, 2'b00, 1'b0);
        tick(); tick();
        check("bhold_bvalid",  32'(bus.sm_bvalid),  32'd1);
        check("bhold_awready", 32'(bus.sm_awready), 32'd0);
        reset = 1'b1;
        tick();
        check("abort_bvalid",  32'(bus.sm_bvalid),  32'd0);
        check("abort_awready", 32'(bus.sm_awready), 32'd1);
        check("abort_wready",  32'(bus.sm_wready),  32'd1);
        check("abort_an",      32'(an),             32'hE);
        check("abort_disp",    32'(disp_hex_r),     32'(DISP_RST));
        reset = 1'b0;
        bus.ms_bready = 1'b1;
        do_read(4'd3, 16'h0003, 2'b00);

        do_write(4'd11, 16'h5A5A, 2'b11, 0, 2'b00, 1'b1);
        do_read(4'd11, 16'h5A5A, 2'b00);

        tick(); tick();
        check("rd_queue_drained", 32'(rd_exp_q.size()), 32'd0);
        check("wr_queue_drained", 32'(wr_exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
